fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width.
REQ-002 Parameter ADDR_W, default 7, SHALL set the address width; depth SHALL be 2^ADDR_W = 128 entries.
REQ-003 clk_w  input  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-004 clk_r  input  1  SHALL be retained for pin compatibility only, SHALL drive no logic, and SHALL be tied to clk_w at integration.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset sampled on the clk_w rising edge.
REQ-006 buf_in  input  8  SHALL carry the write data.
REQ-007 wr_en  input  1  SHALL be the write request.
REQ-008 rd_en  input  1  SHALL be the read request.
REQ-009 thresh_in  input  7  SHALL be the occupancy threshold, unsigned.
REQ-010 buf_out  output  8  SHALL be the registered read data.
REQ-011 buf_empty  output  1  SHALL indicate occupancy == 0.
REQ-012 buf_full  output  1  SHALL indicate occupancy == 128.
REQ-013 fifo_counter  output  8  SHALL give the current occupancy, range 0..128.
REQ-014 uf_check  output  1  SHALL be the underflow (rejected read) indicator.
REQ-015 of_check  output  1  SHALL be the overflow (rejected write) indicator.
REQ-016 thresh_out  output  1  SHALL be the threshold-reached indicator.

Function
REQ-017 Storage SHALL be a 128x8 array with 7-bit write and read pointers that wrap from 127 to 0.
REQ-018 A write SHALL be accepted iff wr_en=1 and buf_full=0; buf_in is stored at wr_ptr and wr_ptr increments.
REQ-019 A read SHALL be accepted iff rd_en=1 and buf_empty=0; mem[rd_ptr] is loaded into buf_out on the same edge and rd_ptr increments (one-cycle latency).
REQ-020 buf_out SHALL hold its value on all cycles without an accepted read.
REQ-021 fifo_counter SHALL be +1 on a write-only accept, -1 on a read-only accept, and unchanged when both or neither are accepted.
REQ-022 buf_empty and buf_full SHALL be decoded combinationally from fifo_counter.
REQ-023 With wr_en=rd_en=1 and the FIFO empty, the write SHALL be accepted, the read rejected, and uf_check SHALL assert.
REQ-024 With wr_en=rd_en=1 and the FIFO full, the read SHALL be accepted, the write rejected, and of_check SHALL assert.
REQ-025 With wr_en=rd_en=1 and 0<count<128, both SHALL be accepted and the count SHALL be unchanged.
REQ-026 of_check SHALL be a registered one-cycle pulse set on the edge after a cycle with wr_en=1 and buf_full=1; the rejected write SHALL not modify memory, pointers, or count.
REQ-027 uf_check SHALL be a registered one-cycle pulse set on the edge after a cycle with rd_en=1 and buf_empty=1; buf_out, pointers, and count SHALL remain unchanged.
REQ-028 thresh_out SHALL equal (fifo_counter >= zero-extended thresh_in) combinationally; thresh_in=0 SHALL yield 1.

Reset
REQ-029 While rst=1 at a clock edge, the pointers, fifo_counter, buf_out, uf_check, and of_check SHALL clear to 0; memory contents SHALL be left unchanged.
REQ-030 After reset, buf_empty SHALL be 1 and buf_full SHALL be 0; thresh_out SHALL follow REQ-028.
REQ-031 Reset SHALL take priority over any concurrent wr_en or rd_en, and reset mid-operation SHALL discard all stored entries.

Verification
REQ-032 Reset, then write A5, 3C, 7E, then read 3 -> buf_out = A5, 3C, 7E one cycle after each read; fifo_counter 3->0; buf_empty = 1.
REQ-033 Write 128 words -> buf_full = 1 and fifo_counter = 128; a 129th write -> of_check pulses 1 for one cycle and the count stays 128; read all 128 -> data matches in order across pointer wrap.
REQ-034 From reset, rd_en=1 -> uf_check pulses 1, buf_out stays 00, fifo_counter stays 0.
REQ-035 thresh_in=15: after 14 writes thresh_out=0, after 15 writes 1; change thresh_in to 30 -> thresh_out=0 immediately.
REQ-036 With count=5, wr_en=rd_en=1 for 4 cycles -> count stays 5 and reads return the oldest data; rst=1 for one edge -> count 0, buf_out 00, buf_empty 1.

Source files
------------

// File: rtl/fifo.sv
// Single-clock 128x8 FIFO with occupancy count, threshold flag and over/underflow pulses.
// Latency: read data is registered and appears on buf_out one cycle after an accepted read.
// Backpressure: writes are dropped when full and reads are dropped when empty, each flagged by a pulse.
module fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk_w,
    input  logic              clk_r,
    input  logic              rst,
    input  logic [DATA_W-1:0] buf_in,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] thresh_in,
    output logic [DATA_W-1:0] buf_out,
    output logic              buf_empty,
    output logic              buf_full,
    output logic [ADDR_W:0]   fifo_counter,
    output logic              uf_check,
    output logic              of_check,
    output logic              thresh_out
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // clk_r is a legacy pin only; everything runs on clk_w.
    logic unused_clk_r;
    assign unused_clk_r = clk_r;

    assign buf_empty  = (fifo_counter == '0);
    assign buf_full   = (fifo_counter == FULL_CNT);
    assign thresh_out = (fifo_counter >= {1'b0, thresh_in});

    assign wr_acc = wr_en && !buf_full;
    assign rd_acc = rd_en && !buf_empty;

    // Storage is deliberately not reset; the cleared pointers make old entries unreachable.
    always_ff @(posedge clk_w) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= buf_in;
        end
    end

    always_ff @(posedge clk_w) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_w) begin
        if (rst) begin
            buf_out <= '0;
        end else if (rd_acc) begin
            buf_out <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_w) begin
        if (rst) begin
            fifo_counter <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   fifo_counter <= fifo_counter + 1'b1;
                2'b01:   fifo_counter <= fifo_counter - 1'b1;
                default: fifo_counter <= fifo_counter;
            endcase
        end
    end

    // Rejected requests are reported one cycle later as single-cycle pulses.
    always_ff @(posedge clk_w) begin
        if (rst) begin
            of_check <= 1'b0;
            uf_check <= 1'b0;
        end else begin
            of_check <= wr_en && buf_full;
            uf_check <= rd_en && buf_empty;
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: a queue of written words is popped and compared as reads complete.
module tb_fifo;

    logic       clk_w;
    logic       clk_r;
    logic       rst;
    logic [7:0] buf_in;
    logic       wr_en;
    logic       rd_en;
    logic [6:0] thresh_in;
    logic [7:0] buf_out;
    logic       buf_empty;
    logic       buf_full;
    logic [7:0] fifo_counter;
    logic       uf_check;
    logic       of_check;
    logic       thresh_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];
    int         model_cnt;
    logic [7:0] last_out;

    fifo dut (
        .clk_w        (clk_w),
        .clk_r        (clk_r),
        .rst          (rst),
        .buf_in       (buf_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .thresh_in    (thresh_in),
        .buf_out      (buf_out),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .fifo_counter (fifo_counter),
        .uf_check     (uf_check),
        .of_check     (of_check),
        .thresh_out   (thresh_out)
    );

    initial begin
        clk_w = 1'b0;
        forever #5 clk_w = ~clk_w;
    end
    assign clk_r = clk_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_w);
        #1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".count"}, 32'(fifo_counter), 32'(model_cnt));
        chk({tag, ".empty"}, 32'(buf_empty), 32'(model_cnt == 0));
        chk({tag, ".full"}, 32'(buf_full), 32'(model_cnt == 128));
        chk({tag, ".thresh"}, 32'(thresh_out), 32'(model_cnt >= int'(thresh_in)));
    endtask

    task automatic do_reset(input logic w, input logic r);
        rst   = 1'b1;
        wr_en = w;
        rd_en = r;
        tick();
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        sb.delete();
        model_cnt = 0;
        last_out  = 8'h00;
        chk("rst.buf_out", 32'(buf_out), 32'h0);
        chk("rst.of", 32'(of_check), 32'h0);
        chk("rst.uf", 32'(uf_check), 32'h0);
        check_status("rst");
    endtask

    // One clock with the given request; expectations come from the bench's own occupancy model.
    task automatic do_cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
        logic wa, ra, exp_of, exp_uf;
        logic [7:0] exp_dat;
        wa     = w && (model_cnt < 128);
        ra     = r && (model_cnt > 0);
        exp_of = w && (model_cnt == 128);
        exp_uf = r && (model_cnt == 0);
        exp_dat = last_out;
        if (ra) exp_dat = sb.pop_front();
        if (wa) sb.push_back(d);
        wr_en  = w;
        rd_en  = r;
        buf_in = d;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_cnt = model_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        last_out  = exp_dat;
        chk({tag, ".dat"}, 32'(buf_out), 32'(exp_dat));
        chk({tag, ".of"}, 32'(of_check), 32'(exp_of));
        chk({tag, ".uf"}, 32'(uf_check), 32'(exp_uf));
        check_status(tag);
    endtask

    initial begin
        logic [7:0] seq3 [3];
        seq3[0] = 8'hA5;
        seq3[1] = 8'h3C;
        seq3[2] = 8'h7E;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; buf_in = 8'h00; thresh_in = 7'd0;
        tick();
        do_reset(1'b0, 1'b0);

        // Three words in, three out, in order.
        for (int i = 0; i < 3; i++) do_cycle("wr3", 1'b1, 1'b0, seq3[i]);
        for (int i = 0; i < 3; i++) do_cycle("rd3", 1'b0, 1'b1, 8'h00);
        chk("rd3.last", 32'(buf_out), 32'h7E);

        // Underflow from reset, then the pulse drops.
        do_reset(1'b0, 1'b0);
        do_cycle("uf", 1'b0, 1'b1, 8'h00);
        chk("uf.pulse", 32'(uf_check), 32'h1);
        do_cycle("uf_idle", 1'b0, 1'b0, 8'h00);

        // Threshold boundary and live threshold change.
        do_reset(1'b0, 1'b0);
        thresh_in = 7'd15;
        for (int i = 0; i < 14; i++) do_cycle("th_wr", 1'b1, 1'b0, 8'(i + 8'h40));
        chk("th.14", 32'(thresh_out), 32'h0);
        do_cycle("th_wr", 1'b1, 1'b0, 8'h4E);
        chk("th.15", 32'(thresh_out), 32'h1);
        thresh_in = 7'd30;
        #1;
        chk("th.30", 32'(thresh_out), 32'h0);
        thresh_in = 7'd0;
        #1;
        chk("th.0", 32'(thresh_out), 32'h1);

        // Fill to full, overflow, simultaneous at full, drain across the pointer wrap.
        do_reset(1'b0, 1'b0);
        thresh_in = 7'd127;
        for (int i = 0; i < 128; i++) do_cycle("fill", 1'b1, 1'b0, 8'($urandom));
        chk("fill.full", 32'(buf_full), 32'h1);
        chk("fill.cnt", 32'(fifo_counter), 32'd128);
        do_cycle("ovf", 1'b1, 1'b0, 8'hEE);
        chk("ovf.pulse", 32'(of_check), 32'h1);
        do_cycle("ovf_idle", 1'b0, 1'b0, 8'h00);
        do_cycle("full_rw", 1'b1, 1'b1, 8'hDD);
        chk("full_rw.of", 32'(of_check), 32'h1);
        for (int i = 0; i < 127; i++) do_cycle("drain", 1'b0, 1'b1, 8'h00);
        chk("drain.empty", 32'(buf_empty), 32'h1);
        do_cycle("empty_rw", 1'b1, 1'b1, 8'h99);
        chk("empty_rw.uf", 32'(uf_check), 32'h1);
        do_cycle("empty_rw_rd", 1'b0, 1'b1, 8'h00);

        // Simultaneous traffic at a mid level, then reset with requests pending.
        do_reset(1'b0, 1'b0);
        thresh_in = 7'd5;
        for (int i = 0; i < 5; i++) do_cycle("mid_wr", 1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) do_cycle("mid_rw", 1'b1, 1'b1, 8'(8'h20 + i));
        chk("mid.cnt", 32'(fifo_counter), 32'd5);
        do_reset(1'b1, 1'b1);
        chk("mid_rst.cnt", 32'(fifo_counter), 32'd0);
        chk("mid_rst.empty", 32'(buf_empty), 32'h1);
        do_cycle("post_rst_rd", 1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
